// File: rtl/chi_sn_responder.sv
`default_nettype none
// ============================================================================
// Module   : chi_sn_responder
// Brief    : CHI-style subordinate-node responder. In-order request FIFO, a
//            fixed-latency access FSM and a 16 x 32-bit backing memory.
//            Optional even-parity protection enabled by CHI_SN_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chi_sn_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request_valid,
    output logic        request_ready,
    input  logic [3:0]  command,
    input  logic [31:0] addr,
    input  logic [7:0]  txnid,
    input  logic [31:0] write_data,
`ifdef CHI_SN_PARITY_EN
    input  logic        write_par,
    output logic        read_par,
`endif
    output logic        response_valid,
    input  logic        response_ready,
    output logic [1:0]  rsp_opcode,
    output logic [7:0]  rsp_txnid,
    output logic [31:0] read_data,
    output logic        busy
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [3:0] c_CMD_RD      = 4'b0001;
    localparam logic [3:0] c_CMD_WR      = 4'b0010;
    localparam logic [1:0] c_OP_COMPDATA = 2'b00;
    localparam logic [1:0] c_OP_COMP     = 2'b01;
    localparam logic [1:0] c_OP_ERROR    = 2'b10;
    localparam logic [3:0] c_LAT_INIT    = 4'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    logic [3:0]         r_fifo_cmd  [FIFO_DEPTH];
    logic [31:0]        r_fifo_addr [FIFO_DEPTH];
    logic [7:0]         r_fifo_id   [FIFO_DEPTH];
    logic [31:0]        r_fifo_wd   [FIFO_DEPTH];
    logic               r_fifo_par  [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_req_ready;

    logic [1:0]         r_state;
    logic [3:0]         r_lat;
    logic [3:0]         r_cur_cmd;
    logic [31:0]        r_cur_addr;
    logic [7:0]         r_cur_id;
    logic [31:0]        r_cur_wd;
    logic               r_cur_par;

    logic [31:0]        r_mem [16];
    logic               r_rsp_valid;
    logic [1:0]         r_rsp_op;
    logic [7:0]         r_rsp_id;
    logic [31:0]        r_rd_data;

    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_cmd_rd;
    logic               w_cmd_wr;
    logic               w_addr_bad;
    logic               w_par_bad;
    logic               w_err;
    logic [3:0]         w_idx;
    logic               w_in_par;

    assign w_push      = request_valid && r_req_ready;
    assign w_pop       = (r_state == c_ST_IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    assign w_cmd_rd   = (r_cur_cmd == c_CMD_RD);
    assign w_cmd_wr   = (r_cur_cmd == c_CMD_WR);
    assign w_addr_bad = (|r_cur_addr[31:6]) || (|r_cur_addr[1:0]);
    assign w_idx      = r_cur_addr[5:2];

`ifdef CHI_SN_PARITY_EN
    assign w_in_par  = write_par;
    assign w_par_bad = w_cmd_wr && (r_cur_par != ^r_cur_wd);
    assign read_par  = ^r_rd_data;
`else
    assign w_in_par  = 1'b0;
    assign w_par_bad = 1'b0 & r_cur_par;
`endif

    assign w_err = w_addr_bad || !(w_cmd_rd || w_cmd_wr) || w_par_bad;

    // Queue storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_fifo_cmd[r_wr_ptr]  <= command;
            r_fifo_addr[r_wr_ptr] <= addr;
            r_fifo_id[r_wr_ptr]   <= txnid;
            r_fifo_wd[r_wr_ptr]   <= write_data;
            r_fifo_par[r_wr_ptr]  <= w_in_par;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_lat       <= '0;
            r_cur_cmd   <= '0;
            r_cur_addr  <= '0;
            r_cur_id    <= '0;
            r_cur_wd    <= '0;
            r_cur_par   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= '0;
            r_rsp_id    <= '0;
            r_rd_data   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count     <= w_count_nxt;
            r_req_ready <= (w_count_nxt < c_CNT_W'(FIFO_DEPTH));

            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_cur_cmd  <= r_fifo_cmd[r_rd_ptr];
                        r_cur_addr <= r_fifo_addr[r_rd_ptr];
                        r_cur_id   <= r_fifo_id[r_rd_ptr];
                        r_cur_wd   <= r_fifo_wd[r_rd_ptr];
                        r_cur_par  <= r_fifo_par[r_rd_ptr];
                        r_lat      <= c_LAT_INIT;
                        r_state    <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    if (r_lat == 4'd0) begin
                        if (w_err) begin
                            r_rsp_op  <= c_OP_ERROR;
                            r_rd_data <= '0;
                        end else if (w_cmd_wr) begin
                            r_mem[w_idx] <= r_cur_wd;
                            r_rsp_op     <= c_OP_COMP;
                            r_rd_data    <= '0;
                        end else begin
                            r_rsp_op  <= c_OP_COMPDATA;
                            r_rd_data <= r_mem[w_idx];
                        end
                        r_rsp_id    <= r_cur_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (response_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign request_ready  = r_req_ready;
    assign response_valid = r_rsp_valid;
    assign rsp_opcode     = r_rsp_op;
    assign rsp_txnid      = r_rsp_id;
    assign read_data      = r_rd_data;
    assign busy           = (r_count != '0) || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_chi_sn_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chi_sn_responder
// Brief    : Scoreboard bench for chi_sn_responder (parity cases need
//            CHI_SN_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chi_sn_responder;

    localparam logic [3:0] c_RD = 4'b0001;
    localparam logic [3:0] c_WR = 4'b0010;
    localparam logic [1:0] c_CDATA = 2'b00;
    localparam logic [1:0] c_COMP  = 2'b01;
    localparam logic [1:0] c_ERR   = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic        request_valid;
    logic        request_ready;
    logic [3:0]  command;
    logic [31:0] addr;
    logic [7:0]  txnid;
    logic [31:0] write_data;
    logic        response_valid;
    logic        response_ready;
    logic [1:0]  rsp_opcode;
    logic [7:0]  rsp_txnid;
    logic [31:0] read_data;
    logic        busy;
`ifdef CHI_SN_PARITY_EN
    logic        write_par;
    logic        read_par;
`endif

    typedef struct packed {
        logic [1:0]  op;
        logic [7:0]  id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    chi_sn_responder dut (
        .clk            (clk),
        .reset          (reset),
        .request_valid  (request_valid),
        .request_ready  (request_ready),
        .command        (command),
        .addr           (addr),
        .txnid          (txnid),
        .write_data     (write_data),
`ifdef CHI_SN_PARITY_EN
        .write_par      (write_par),
        .read_par       (read_par),
`endif
        .response_valid (response_valid),
        .response_ready (response_ready),
        .rsp_opcode     (rsp_opcode),
        .rsp_txnid      (rsp_txnid),
        .read_data      (read_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every handshaked response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && response_valid && response_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'd0, response_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_opcode", {30'd0, rsp_opcode}, {30'd0, e.op});
                chk("rsp_txnid", {24'd0, rsp_txnid}, {24'd0, e.id});
                chk("read_data", read_data, e.data);
`ifdef CHI_SN_PARITY_EN
                chk("read_par", {31'd0, read_par}, {31'd0, ^e.data});
`endif
            end
        end
    end

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [7:0] id,
                        input logic [31:0] d, input logic bad_par, input bit do_exp,
                        input logic [1:0] eop, input logic [31:0] edata);
        bit ok;
        ok = 1'b0;
        command = cmd; addr = a; txnid = id; write_data = d;
`ifdef CHI_SN_PARITY_EN
        write_par = (^d) ^ bad_par;
`endif
        request_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (request_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_accept", {31'd0, request_ready}, 32'd1);
        else if (do_exp) sb.push_back('{op: eop, id: id, data: edata});
        @(posedge clk); #1;
        request_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0 && !busy) break;
            @(posedge clk); #1;
        end
        chk("drain_queue", sb.size(), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int acc;
        bit hs;
        reset = 1'b0; request_valid = 1'b0; response_ready = 1'b1;
        command = '0; addr = '0; txnid = '0; write_data = '0;
`ifdef CHI_SN_PARITY_EN
        write_par = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_request_ready", {31'd0, request_ready}, 32'd0);
        chk("rst_response_valid", {31'd0, response_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_opcode", {30'd0, rsp_opcode}, 32'd0);
        chk("rst_rsp_txnid", {24'd0, rsp_txnid}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {31'd0, request_ready}, 32'd1);

        // Write then read back, with latency measured from the accept edge.
        send(c_WR, 32'h10, 8'h01, 32'hABCD1234, 1'b0, 1'b1, c_COMP, 32'h0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (response_valid) break;
        end
        chk("latency", lat, 32'd3);
        send(c_RD, 32'h10, 8'h02, 32'h0, 1'b0, 1'b1, c_CDATA, 32'hABCD1234);
        drain();

        // Error cases leave memory untouched.
        send(c_WR, 32'h40, 8'h03, 32'h11111111, 1'b0, 1'b1, c_ERR, 32'h0);
        send(4'b0101, 32'h10, 8'h04, 32'h22222222, 1'b0, 1'b1, c_ERR, 32'h0);
        send(c_WR, 32'h11, 8'h05, 32'h33333333, 1'b0, 1'b1, c_ERR, 32'h0);
        send(c_RD, 32'h10, 8'h06, 32'h0, 1'b0, 1'b1, c_CDATA, 32'hABCD1234);
        drain();

        // Back-pressure: one request in the FSM plus a full FIFO.
        response_ready = 1'b0;
        acc = 0;
        request_valid = 1'b1;
        command = c_WR;
        for (int c = 0; c < 12; c++) begin
            addr = 32'(acc * 4); txnid = 8'(8'h20 + acc); write_data = 32'(32'h1000 + acc);
`ifdef CHI_SN_PARITY_EN
            write_par = ^write_data;
`endif
            @(negedge clk);
            hs = request_ready;
            if (hs) sb.push_back('{op: c_COMP, id: txnid, data: 32'h0});
            @(posedge clk); #1;
            if (hs) acc++;
        end
        request_valid = 1'b0;
        chk("bp_accepted", acc, 32'd5);
        chk("bp_ready_low", {31'd0, request_ready}, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        response_ready = 1'b1;
        drain();

        // Response held stable under back-pressure.
        response_ready = 1'b0;
        send(c_RD, 32'h10, 8'h30, 32'h0, 1'b0, 1'b1, c_CDATA, 32'h00001004);
        for (int i = 0; i < 20; i++) begin
            if (response_valid) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, response_valid}, 32'd1);
            chk("hold_txnid", {24'd0, rsp_txnid}, 32'h30);
            chk("hold_data", read_data, 32'h00001004);
        end
        response_ready = 1'b1;
        drain();

        // Reset mid-access with two requests queued.
        send(c_WR, 32'h10, 8'h41, 32'hDEADBEEF, 1'b0, 1'b0, c_COMP, 32'h0);
        send(c_RD, 32'h10, 8'h42, 32'h0, 1'b0, 1'b0, c_CDATA, 32'h0);
        send(c_RD, 32'h14, 8'h43, 32'h0, 1'b0, 1'b0, c_CDATA, 32'h0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, response_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, request_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ready_after", {31'd0, request_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_idle_busy", {31'd0, busy}, 32'd0);
        send(c_RD, 32'h10, 8'h44, 32'h0, 1'b0, 1'b1, c_CDATA, 32'h0);
        drain();

`ifdef CHI_SN_PARITY_EN
        send(c_WR, 32'h08, 8'h50, 32'h1, 1'b1, 1'b1, c_ERR, 32'h0);
        send(c_RD, 32'h08, 8'h51, 32'h0, 1'b0, 1'b1, c_CDATA, 32'h0);
        send(c_WR, 32'h08, 8'h52, 32'h1, 1'b0, 1'b1, c_COMP, 32'h0);
        send(c_RD, 32'h08, 8'h53, 32'h0, 1'b0, 1'b1, c_CDATA, 32'h1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
